// File: rtl/ps2_rx_controller.sv
// PS/2 keyboard receiver: synchronizes and filters the pins, sequences the 11-bit frame,
// folds E0/F0 prefixes into flags and hands finished scan codes out through a valid/ready register.
module ps2_rx_controller #(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 5000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       kb_clk,
    input  logic       data,
    output logic [7:0] scan_code,
    output logic       break_flag,
    output logic       ext_flag,
    output logic       scan_valid,
    input  logic       scan_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int FCW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int TCW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DATA   = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;
    localparam logic [1:0] ST_STOP   = 2'd3;

    logic [SYNC_STAGES-1:0] clk_sync_r;
    logic [SYNC_STAGES-1:0] dat_sync_r;
    logic                   clk_s;
    logic                   dat_s;
    logic                   filt_clk_r;
    logic [FCW-1:0]         filt_cnt_r;
    logic                   strobe_r;

    logic [1:0]     state_r,     state_nxt;
    logic [2:0]     bit_cnt_r,   bit_cnt_nxt;
    logic [7:0]     shift_r,     shift_nxt;
    logic           par_ok_r,    par_ok_nxt;
    logic [TCW-1:0] tmo_r,       tmo_nxt;
    logic           p_ext_r,     p_ext_nxt;
    logic           p_brk_r,     p_brk_nxt;
    logic [7:0]     code_r,      code_nxt;
    logic           brk_r,       brk_nxt;
    logic           ext_r,       ext_nxt;
    logic           valid_r,     valid_nxt;
    logic           ferr_r,      ferr_nxt;
    logic           ovr_r,       ovr_nxt;
    logic           tmo_hit_s;

    assign clk_s = clk_sync_r[SYNC_STAGES-1];
    assign dat_s = dat_sync_r[SYNC_STAGES-1];

    // Pin synchronizers, reset to the idle-high bus level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync_r <= {SYNC_STAGES{1'b1}};
            dat_sync_r <= {SYNC_STAGES{1'b1}};
        end else begin
            clk_sync_r <= {clk_sync_r[SYNC_STAGES-2:0], kb_clk};
            dat_sync_r <= {dat_sync_r[SYNC_STAGES-2:0], data};
        end
    end

    // Glitch filter: flip only after FILTER_LEN consecutive differing samples; strobe on the falling flip.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_clk_r <= 1'b1;
            filt_cnt_r <= {FCW{1'b0}};
            strobe_r   <= 1'b0;
        end else begin
            strobe_r <= 1'b0;
            if (clk_s == filt_clk_r) begin
                filt_cnt_r <= {FCW{1'b0}};
            end else if (filt_cnt_r == FCW'(FILTER_LEN - 1)) begin
                filt_clk_r <= clk_s;
                filt_cnt_r <= {FCW{1'b0}};
                strobe_r   <= ~clk_s;
            end else begin
                filt_cnt_r <= filt_cnt_r + FCW'(1);
            end
        end
    end

    // A strobe in the same cycle always beats the timeout.
    assign tmo_hit_s = !strobe_r && (state_r != ST_IDLE) && (tmo_r == TCW'(TIMEOUT_CYCLES - 1));

    // Frame sequencer, prefix folding and holding-register next state.
    always_comb begin
        state_nxt   = state_r;
        bit_cnt_nxt = bit_cnt_r;
        shift_nxt   = shift_r;
        par_ok_nxt  = par_ok_r;
        p_ext_nxt   = p_ext_r;
        p_brk_nxt   = p_brk_r;
        code_nxt    = code_r;
        brk_nxt     = brk_r;
        ext_nxt     = ext_r;
        ferr_nxt    = 1'b0;
        ovr_nxt     = 1'b0;
        if (valid_r && scan_ready) begin
            valid_nxt = 1'b0;
        end else begin
            valid_nxt = valid_r;
        end
        if (strobe_r) begin
            tmo_nxt = {TCW{1'b0}};
        end else if (state_r != ST_IDLE) begin
            tmo_nxt = tmo_r + TCW'(1);
        end else begin
            tmo_nxt = {TCW{1'b0}};
        end

        if (strobe_r) begin
            case (state_r)
                ST_IDLE: begin
                    if (!dat_s) begin
                        state_nxt   = ST_DATA;
                        bit_cnt_nxt = 3'd0;
                    end else begin
                        ferr_nxt = 1'b1;
                    end
                end
                ST_DATA: begin
                    shift_nxt[bit_cnt_r] = dat_s;
                    bit_cnt_nxt          = bit_cnt_r + 3'd1;
                    if (bit_cnt_r == 3'd7) begin
                        state_nxt = ST_PARITY;
                    end else begin
                        state_nxt = ST_DATA;
                    end
                end
                ST_PARITY: begin
                    par_ok_nxt = ^{shift_r, dat_s};
                    state_nxt  = ST_STOP;
                end
                ST_STOP: begin
                    state_nxt = ST_IDLE;
                    if (par_ok_r && dat_s) begin
                        if (shift_r == 8'hE0) begin
                            p_ext_nxt = 1'b1;
                        end else if (shift_r == 8'hF0) begin
                            p_brk_nxt = 1'b1;
                        end else begin
                            p_ext_nxt = 1'b0;
                            p_brk_nxt = 1'b0;
                            if (!valid_r || scan_ready) begin
                                code_nxt  = shift_r;
                                brk_nxt   = p_brk_r;
                                ext_nxt   = p_ext_r;
                                valid_nxt = 1'b1;
                            end else begin
                                ovr_nxt = 1'b1;
                            end
                        end
                    end else begin
                        ferr_nxt  = 1'b1;
                        p_ext_nxt = 1'b0;
                        p_brk_nxt = 1'b0;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end else if (tmo_hit_s) begin
            state_nxt = ST_IDLE;
            tmo_nxt   = {TCW{1'b0}};
            ferr_nxt  = 1'b1;
            p_ext_nxt = 1'b0;
            p_brk_nxt = 1'b0;
        end else begin
            state_nxt = state_r;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            bit_cnt_r <= 3'd0;
            shift_r   <= 8'h00;
            par_ok_r  <= 1'b0;
            tmo_r     <= {TCW{1'b0}};
            p_ext_r   <= 1'b0;
            p_brk_r   <= 1'b0;
            code_r    <= 8'h00;
            brk_r     <= 1'b0;
            ext_r     <= 1'b0;
            valid_r   <= 1'b0;
            ferr_r    <= 1'b0;
            ovr_r     <= 1'b0;
        end else begin
            state_r   <= state_nxt;
            bit_cnt_r <= bit_cnt_nxt;
            shift_r   <= shift_nxt;
            par_ok_r  <= par_ok_nxt;
            tmo_r     <= tmo_nxt;
            p_ext_r   <= p_ext_nxt;
            p_brk_r   <= p_brk_nxt;
            code_r    <= code_nxt;
            brk_r     <= brk_nxt;
            ext_r     <= ext_nxt;
            valid_r   <= valid_nxt;
            ferr_r    <= ferr_nxt;
            ovr_r     <= ovr_nxt;
        end
    end

    assign scan_code  = code_r;
    assign break_flag = brk_r;
    assign ext_flag   = ext_r;
    assign scan_valid = valid_r;
    assign frame_err  = ferr_r;
    assign overrun    = ovr_r;
    assign busy       = (state_r != ST_IDLE);

endmodule
